// File: rtl/sisc_ctrl_pkg.sv
// Shared types and constants for the SISC multicycle controller.
// Holds the state encoding, the opcode map, the alu_op codes and the branch-condition rule.
package sisc_ctrl_pkg;

    typedef enum logic [2:0] {
        S_START     = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEM       = 3'd4,
        S_WRITEBACK = 3'd5,
        S_HALT      = 3'd6,
        S_FAULT     = 3'd7
    } state_t;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_RTYPE = 4'h1;
    localparam logic [3:0] OP_ITYPE = 4'h2;
    localparam logic [3:0] OP_LOD   = 4'h3;
    localparam logic [3:0] OP_STR   = 4'h4;
    localparam logic [3:0] OP_BRA   = 4'h5;
    localparam logic [3:0] OP_BRR   = 4'h6;
    localparam logic [3:0] OP_BNE   = 4'h7;
    localparam logic [3:0] OP_HLT   = 4'hF;

    localparam logic [1:0] ALU_RR   = 2'b00;
    localparam logic [1:0] ALU_RI   = 2'b01;
    localparam logic [1:0] ALU_ADDR = 2'b10;

    // condHit is |(stat & mm); BNE branches on the complement of that test.
    function automatic logic branch_taken(input logic [3:0] op, input logic condHit);
        case (op)
            OP_BRA, OP_BRR: return condHit;
            OP_BNE:         return !condHit;
            default:        return 1'b0;
        endcase
    endfunction

    function automatic logic is_legal(input logic [3:0] op);
        return (op <= OP_BNE) || (op == OP_HLT);
    endfunction

endpackage

// File: rtl/sisc_wait_timer.sv
// Counts consecutive MEM cycles without an acknowledge.
// o_expired flags the cycle whose increment would reach LIMIT.
module sisc_wait_timer #(
    parameter int LIMIT = 15
) (
    input  logic i_clk,
    input  logic i_rst_f,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_f) begin
        if (!i_rst_f) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = i_enable && (r_count == CW'(LIMIT - 1));

endmodule

// File: rtl/sisc_ctrl_mc.sv
// Multicycle SISC control unit: Moore FSM sequencing fetch/decode/execute/mem/writeback
// with a req/ack data-memory handshake, bounded wait with sticky fault, and halt.
module sisc_ctrl_mc
    import sisc_ctrl_pkg::*;
#(
    parameter int OPW         = 4,
    parameter int MMW         = 4,
    parameter int STW         = 4,
    parameter int AOPW        = 2,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic            i_clk,
    input  logic            i_rst_f,
    input  logic [OPW-1:0]  i_opcode,
    input  logic [MMW-1:0]  i_mm,
    input  logic [STW-1:0]  i_stat,
    input  logic            i_dm_ack,
    output logic            o_rf_we,
    output logic [AOPW-1:0] o_alu_op,
    output logic            o_wb_sel,
    output logic            o_br_sel,
    output logic            o_pc_sel,
    output logic            o_pc_write,
    output logic            o_pc_rst,
    output logic            o_ir_load,
    output logic            o_rb_sel,
    output logic            o_mm_sel,
    output logic            o_dm_req,
    output logic            o_dm_we,
    output logic            o_halted,
    output logic            o_fault,
    output logic            o_illegal
);

    state_t     r_state;
    state_t     w_nextState;
    logic [3:0] w_op;
    logic       w_condHit;
    logic       w_isMem;
    logic       w_memWait;
    logic       w_expired;

    assign w_op      = 4'(i_opcode);
    assign w_condHit = |(i_stat & i_mm);
    assign w_isMem   = (w_op == OP_LOD) || (w_op == OP_STR);
    assign w_memWait = (r_state == S_MEM) && !i_dm_ack;

    sisc_wait_timer #(
        .LIMIT(MEM_TIMEOUT)
    ) u_timer (
        .i_clk    (i_clk),
        .i_rst_f  (i_rst_f),
        .i_clear  (!w_memWait),
        .i_enable (w_memWait),
        .o_expired(w_expired)
    );

    always_ff @(posedge i_clk or negedge i_rst_f) begin
        if (!i_rst_f) begin
            r_state <= S_START;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_START:     w_nextState = S_FETCH;
            S_FETCH:     w_nextState = S_DECODE;
            S_DECODE: begin
                case (w_op)
                    OP_RTYPE, OP_ITYPE, OP_LOD, OP_STR: w_nextState = S_EXECUTE;
                    OP_HLT:                             w_nextState = S_HALT;
                    default:                            w_nextState = S_FETCH;
                endcase
            end
            S_EXECUTE:   w_nextState = w_isMem ? S_MEM : S_WRITEBACK;
            // An ack in the final permitted cycle still completes the transfer.
            S_MEM: begin
                if (i_dm_ack) begin
                    w_nextState = (w_op == OP_STR) ? S_FETCH : S_WRITEBACK;
                end else if (w_expired) begin
                    w_nextState = S_FAULT;
                end
            end
            S_WRITEBACK: w_nextState = S_FETCH;
            S_HALT:      w_nextState = S_HALT;
            S_FAULT:     w_nextState = S_FAULT;
            default:     w_nextState = S_START;
        endcase
    end

    always_comb begin
        o_rf_we    = 1'b0;
        o_alu_op   = AOPW'(ALU_RR);
        o_wb_sel   = 1'b0;
        o_br_sel   = 1'b0;
        o_pc_sel   = 1'b0;
        o_pc_write = 1'b0;
        o_pc_rst   = 1'b0;
        o_ir_load  = 1'b0;
        o_rb_sel   = 1'b0;
        o_mm_sel   = 1'b0;
        o_dm_req   = 1'b0;
        o_dm_we    = 1'b0;
        o_halted   = 1'b0;
        o_fault    = 1'b0;
        o_illegal  = 1'b0;
        case (r_state)
            S_START: o_pc_rst = 1'b1;
            S_FETCH: begin
                o_ir_load  = 1'b1;
                o_pc_write = 1'b1;
            end
            S_DECODE: begin
                o_illegal = !is_legal(w_op);
                if (branch_taken(w_op, w_condHit)) begin
                    o_pc_write = 1'b1;
                    o_pc_sel   = 1'b1;
                    o_br_sel   = (w_op != OP_BRA);
                end
            end
            S_EXECUTE: begin
                if (w_op == OP_ITYPE) begin
                    o_alu_op = AOPW'(ALU_RI);
                end else if (w_isMem) begin
                    o_alu_op = AOPW'(ALU_ADDR);
                end
                o_rb_sel = (w_op == OP_STR);
            end
            S_MEM: begin
                o_dm_req = 1'b1;
                o_dm_we  = (w_op == OP_STR);
                o_rb_sel = (w_op == OP_STR);
                o_mm_sel = (i_mm == '0);
            end
            // Loads keep the MEM-phase address select through writeback.
            S_WRITEBACK: begin
                o_rf_we  = 1'b1;
                o_wb_sel = (w_op == OP_LOD);
                o_mm_sel = (w_op == OP_LOD) && (i_mm == '0);
            end
            S_HALT:  o_halted = 1'b1;
            S_FAULT: o_fault  = 1'b1;
            default: o_pc_rst = 1'b1;
        endcase
    end

endmodule
